// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : ex_muldiv_unit
//  Purpose  : Multi-cycle multiply/divide engine for the EX stage. Selects the
//             rs/rt operands through the forwarding muxes, runs an iterative
//             shift-add multiply or restoring shift-subtract divide on operand
//             magnitudes, applies the sign fixup and writes {hi,lo}.
//  Ports    : clk, rst (async, active-low)
//             start/op/flush           - issue, opcode, abort
//             rdata_1/2, data_out_MEM/WB, FWA/FWB - operand sources and selects
//             stall_req, busy          - pipeline hold / engine occupied
//             done, we_hi, we_lo       - one-cycle result-valid pulse
//             hi_out, lo_out           - product or remainder/quotient
//             div_by_zero              - pulses with done on a zero divisor
//  Revision : 1.0 - initial release
// ============================================================================
module ex_muldiv_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [1:0]            op,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] rdata_1,
   input  logic [DATA_WIDTH-1:0] rdata_2,
   input  logic [DATA_WIDTH-1:0] data_out_MEM,
   input  logic [DATA_WIDTH-1:0] data_out_WB,
   input  logic [1:0]            FWA,
   input  logic [1:0]            FWB,
   output logic                  stall_req,
   output logic                  busy,
   output logic                  done,
   output logic                  we_hi,
   output logic                  we_lo,
   output logic [DATA_WIDTH-1:0] hi_out,
   output logic [DATA_WIDTH-1:0] lo_out,
   output logic                  div_by_zero
);

   localparam int W = DATA_WIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state;
   logic [CNT_WIDTH-1:0] cnt;
   logic                 is_div;
   logic                 neg_q;     // product sign (MUL) or quotient sign (DIV)
   logic                 neg_r;     // remainder sign = dividend sign
   logic [W-1:0]         operand;   // multiplicand or divisor magnitude
   logic [W-1:0]         acc_hi;    // partial product high half / partial remainder
   logic [W-1:0]         acc_lo;    // multiplier being shifted out / quotient being shifted in

   // ---------------------------------------------------------------------
   // Operand selection and magnitude capture
   // ---------------------------------------------------------------------
   logic [W-1:0] opa, opb, a_mag, b_mag;
   logic         signed_op, div_op, a_neg, b_neg;

   always_comb begin
      case (FWA)
         2'b01:   opa = data_out_MEM;
         2'b10:   opa = data_out_WB;
         default: opa = rdata_1;
      endcase
      case (FWB)
         2'b01:   opb = data_out_MEM;
         2'b10:   opb = data_out_WB;
         default: opb = rdata_2;
      endcase
      signed_op = ~op[0];
      div_op    = op[1];
      a_neg     = signed_op & opa[W-1];
      b_neg     = signed_op & opb[W-1];
      // The most-negative value negates to itself, which is still the correct
      // unsigned magnitude.
      a_mag     = a_neg ? -opa : opa;
      b_mag     = b_neg ? -opb : opb;
   end

   // ---------------------------------------------------------------------
   // One iteration step and the final sign fixup
   // ---------------------------------------------------------------------
   logic [W:0]     mul_sum, div_trial;
   logic [W-1:0]   step_hi, step_lo, fix_hi, fix_lo;
   logic [2*W-1:0] prod, prod_fix;

   always_comb begin
      // Shift-add: add the multiplicand when the multiplier LSB is set, then
      // shift the whole {carry, hi, lo} right by one.
      mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
      // Restoring divide: shift the next dividend bit into the remainder and
      // try to subtract the divisor; the borrow bit decides the quotient bit.
      div_trial = {acc_hi, acc_lo[W-1]} - {1'b0, operand};

      if (is_div) begin
         if (!div_trial[W]) begin
            step_hi = div_trial[W-1:0];
            step_lo = {acc_lo[W-2:0], 1'b1};
         end else begin
            step_hi = {acc_hi[W-2:0], acc_lo[W-1]};
            step_lo = {acc_lo[W-2:0], 1'b0};
         end
      end else begin
         step_hi = mul_sum[W:1];
         step_lo = {mul_sum[0], acc_lo[W-1:1]};
      end

      prod     = {step_hi, step_lo};
      prod_fix = neg_q ? -prod : prod;
      if (is_div) begin
         fix_hi = neg_r ? -step_hi : step_hi;
         fix_lo = neg_q ? -step_lo : step_lo;
      end else begin
         fix_hi = prod_fix[2*W-1:W];
         fix_lo = prod_fix[W-1:0];
      end
   end

   // ---------------------------------------------------------------------
   // Control FSM and result registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         cnt         <= '0;
         is_div      <= 1'b0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         operand     <= '0;
         acc_hi      <= '0;
         acc_lo      <= '0;
         hi_out      <= '0;
         lo_out      <= '0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         if (flush) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     if (div_op && (opb == '0)) begin
                        // Zero divisor short-circuits straight to DONE.
                        state       <= DONE;
                        lo_out      <= '1;
                        hi_out      <= opa;
                        done        <= 1'b1;
                        div_by_zero <= 1'b1;
                     end else begin
                        state   <= CALC;
                        cnt     <= CNT_WIDTH'(W);
                        is_div  <= div_op;
                        neg_q   <= a_neg ^ b_neg;
                        neg_r   <= a_neg;
                        operand <= b_mag;
                        acc_hi  <= '0;
                        acc_lo  <= a_mag;
                     end
                  end
               end
               CALC: begin
                  acc_hi <= step_hi;
                  acc_lo <= step_lo;
                  cnt    <= cnt - CNT_WIDTH'(1);
                  if (cnt == CNT_WIDTH'(1)) begin
                     state  <= DONE;
                     hi_out <= fix_hi;
                     lo_out <= fix_lo;
                     done   <= 1'b1;
                  end
               end
               default: state <= IDLE;   // DONE: start here is ignored
            endcase
         end
      end
   end

   assign busy      = (state != IDLE);
   assign stall_req = ((state == IDLE) & start & ~flush) | (state == CALC);
   assign we_hi     = done;
   assign we_lo     = done;

endmodule
`default_nettype wire
